stack_frame_ctrl: RTL and testbench
===================================

Name: stack_frame_ctrl

Overview:
Initiator side of the hardware stack interface. It drives push, pop and data into the stack, and consumes the stack's top-of-stack output.
- On a save request it reads a fixed-size frame of FrameWords words from a register-file port and pushes them one per cycle.
- On a restore request it pops the frame back and writes it into the register file in reverse order.
- It sits between the interrupt/context logic and the stack instance, and tracks stack occupancy.

Parameters:
StackDepth, 4, number of stack entries; must match the attached stack.
DataWidth, 8, word width; must match the attached stack.
FrameWords, 2, words per frame; must be at least 2 and at most StackDepth.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
save_req  in  1  request a frame save; sampled only in IDLE.
restore_req  in  1  request a frame restore; sampled only in IDLE.
busy  out  1  high while in SAVE or RESTORE.
done  out  1  one-cycle pulse after the last push or pop of a frame.
err  out  1  one-cycle pulse when a request is rejected.
level  out  $clog2(StackDepth+1)  number of words currently held in the stack.
rf_addr  out  $clog2(FrameWords)  register-file word index, used for both read and write.
rf_rdata  in  DataWidth  register-file read data; combinational from rf_addr.
rf_we  out  1  register-file write enable.
rf_wdata  out  DataWidth  register-file write data.
stk_push  out  1  drives the stack's push input.
stk_pop  out  1  drives the stack's pop input.
stk_wdata  out  DataWidth  drives the stack's data_in.
stk_rdata  in  DataWidth  the stack's data_out (current top of stack).

Behaviour:
Interface and reset:
- One clock; reset is asynchronous and active-high.
- Reset values: state IDLE, cnt 0, level 0, busy/done/err 0.
- All combinational outputs are 0 in IDLE, including rf_addr 0.

Stack timing (the attached stack's contract):
- A push or pop takes effect at the clock edge.
- stk_rdata shows the new top in the following cycle.
- The stack has no full/empty detection; its index wraps.

State IDLE:
- save_req=1 and level+FrameWords<=StackDepth -> SAVE, cnt=0.
- save_req=1 and level+FrameWords>StackDepth -> err pulse next cycle; stay IDLE; no push.
- Otherwise restore_req=1 and level>=FrameWords -> RESTORE, cnt=0.
- Otherwise restore_req=1 and level<FrameWords -> err pulse next cycle; stay IDLE; no pop.
- save_req and restore_req together: save has priority. restore_req is dropped without an error. If the save itself is rejected, only err pulses.

State SAVE (exactly FrameWords cycles):
- rf_addr=cnt, stk_push=1, stk_wdata=rf_rdata.
- Each edge: cnt+1, level+1.
- At the edge where cnt==FrameWords-1: go to IDLE, done=1 for the next cycle.
- Result: word FrameWords-1 ends on top of the stack.

State RESTORE (exactly FrameWords cycles):
- rf_addr=FrameWords-1-cnt, rf_we=1, rf_wdata=stk_rdata, stk_pop=1.
- Each edge: cnt+1, level-1.
- The register write and the pop commit on the same edge.
- Exit and done pulse as in SAVE.

General rules:
- stk_push and stk_pop are never high together.
- Requests while busy are ignored and not queued.
- Latency: request cycle + FrameWords busy cycles; done is high in the cycle after the last transfer.
- level arithmetic is unsigned and cannot wrap when checks are enabled.
- Reset mid-operation: immediately IDLE, level 0. The stack must share the same reset, so its index returns to its reset value.

Optional Feature:
Macro: STACK_FRAME_CTRL_CHECK_EN.
- Defined: level tracking plus overflow/underflow rejection, as described above.
- Not defined:
  - level is tied to 0 and err to 0.
  - Every save/restore in IDLE is accepted.
  - The stack index is allowed to wrap, silently overwriting old entries (legacy behaviour, smaller area).

Decomposition:
- Package stack_frame_ctrl_pkg holds the state typedef (enum logic [1:0] {IDLE, SAVE, RESTORE}) and the width helper constants.
- No sub-module: the FSM, counter and level register are small.
- The stack itself is instantiated beside this block at the same hierarchy level; the bench instantiates both.

Test Plan:
Common setup: StackDepth=4, DataWidth=8, FrameWords=2, macro defined, 2-entry register-file model.
1. Reset held, then released -> busy=0, level=0, stk_push=stk_pop=0; stack index_out=3.
2. rf={0xA1,0xB2}, one-cycle save_req -> two push cycles; stack index_out=1, data_out=0xB2, level=2; one done pulse.
3. After scenario 2, clear rf to 0, one-cycle restore_req -> writes rf[1]=0xB2 then rf[0]=0xA1; level=0, index_out=3; done pulse.
4. Two saves (level=4), then a third save_req -> err pulse, no stk_push, level stays 4. Then restore at level=0 after two restores -> err pulse, no stk_pop.
5. At level=2, save_req and restore_req in the same cycle -> save runs and level=4. A restore_req raised mid-save is ignored. Reset asserted in the first SAVE cycle -> busy=0 and level=0 at once.
6. Macro undefined, three consecutive saves -> all accepted, err never pulses, stack index wraps to 3 after the fourth push.

Source files
------------

// File: rtl/stack_frame_ctrl_pkg.sv
// Shared types and width helpers for the stack frame save/restore controller.
package stack_frame_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAVE    = 2'd1,
    RESTORE = 2'd2
  } state_e;

  localparam int DEF_STACK_DEPTH = 4;
  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_FRAME_WORDS = 2;

  // Occupancy must represent 0..depth inclusive, hence depth+1.
  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int addr_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/stack_frame_ctrl.sv
// Pushes a register-file frame onto an external stack and pops it back in reverse.
// Define STACK_FRAME_CTRL_CHECK_EN for level tracking with overflow/underflow rejection.
module stack_frame_ctrl
  import stack_frame_ctrl_pkg::*;
#(
  parameter int StackDepth = DEF_STACK_DEPTH,
  parameter int DataWidth  = DEF_DATA_WIDTH,
  parameter int FrameWords = DEF_FRAME_WORDS,
  localparam int LevelW    = level_width(StackDepth),
  localparam int AddrW     = addr_width(FrameWords)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 save_req,
  input  logic                 restore_req,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [LevelW-1:0]    level,
  output logic [AddrW-1:0]     rf_addr,
  input  logic [DataWidth-1:0] rf_rdata,
  output logic                 rf_we,
  output logic [DataWidth-1:0] rf_wdata,
  output logic                 stk_push,
  output logic                 stk_pop,
  output logic [DataWidth-1:0] stk_wdata,
  input  logic [DataWidth-1:0] stk_rdata
);

  state_e           state_q, state_d;
  logic [AddrW-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             save_ok, restore_ok;
  logic             last_word;

`ifdef STACK_FRAME_CTRL_CHECK_EN
  logic [LevelW-1:0] level_q, level_d;
  logic              err_q, err_d;

  assign save_ok    = (int'(level_q) + FrameWords) <= StackDepth;
  assign restore_ok = int'(level_q) >= FrameWords;
  assign level      = level_q;
  assign err        = err_q;
`else
  // Legacy build: no occupancy tracking, the stack index may wrap.
  assign save_ok    = 1'b1;
  assign restore_ok = 1'b1;
  assign level      = '0;
  assign err        = 1'b0;
`endif

  assign last_word = (cnt_q == AddrW'(FrameWords - 1));
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    rf_addr   = '0;
    rf_we     = 1'b0;
    rf_wdata  = '0;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    stk_wdata = '0;
`ifdef STACK_FRAME_CTRL_CHECK_EN
    level_d   = level_q;
    err_d     = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        // Save wins over a simultaneous restore; the restore is dropped silently.
        if (save_req) begin
          if (save_ok) begin
            state_d = SAVE;
            cnt_d   = '0;
          end
`ifdef STACK_FRAME_CTRL_CHECK_EN
          else err_d = 1'b1;
`endif
        end else if (restore_req) begin
          if (restore_ok) begin
            state_d = RESTORE;
            cnt_d   = '0;
          end
`ifdef STACK_FRAME_CTRL_CHECK_EN
          else err_d = 1'b1;
`endif
        end
      end
      SAVE: begin
        rf_addr   = cnt_q;
        stk_push  = 1'b1;
        stk_wdata = rf_rdata;
        cnt_d     = cnt_q + 1'b1;
`ifdef STACK_FRAME_CTRL_CHECK_EN
        level_d   = level_q + 1'b1;
`endif
        if (last_word) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
      RESTORE: begin
        // Top of stack holds the highest word, so walk the register file downwards.
        rf_addr  = AddrW'(FrameWords - 1) - cnt_q;
        rf_we    = 1'b1;
        rf_wdata = stk_rdata;
        stk_pop  = 1'b1;
        cnt_d    = cnt_q + 1'b1;
`ifdef STACK_FRAME_CTRL_CHECK_EN
        level_d  = level_q - 1'b1;
`endif
        if (last_word) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

`ifdef STACK_FRAME_CTRL_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= '0;
      err_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      err_q   <= err_d;
    end
  end
`endif

endmodule

// File: tb/tb_stack_frame_ctrl.sv
// Directed bench for stack_frame_ctrl with a 4-entry stack model and a 2-word register file.
module tb_stack_frame_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       save_req, restore_req;
  logic       busy, done, err;
  logic [2:0] level;
  logic [0:0] rf_addr;
  logic [7:0] rf_rdata, rf_wdata;
  logic       rf_we;
  logic       stk_push, stk_pop;
  logic [7:0] stk_wdata, stk_rdata;

  always #5 clk = ~clk;

  stack_frame_ctrl #(.StackDepth(4), .DataWidth(8), .FrameWords(2)) dut (
    .clk(clk), .reset(reset), .save_req(save_req), .restore_req(restore_req),
    .busy(busy), .done(done), .err(err), .level(level),
    .rf_addr(rf_addr), .rf_rdata(rf_rdata), .rf_we(rf_we), .rf_wdata(rf_wdata),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_wdata(stk_wdata), .stk_rdata(stk_rdata)
  );

  // Stack model: index resets to depth-1, push pre-increments, data_out is mem[index].
  logic [7:0] stk_mem [4];
  logic [1:0] stk_idx;
  assign stk_rdata = stk_mem[stk_idx];
  always @(posedge clk or posedge reset) begin
    if (reset) stk_idx <= 2'd3;
    else if (stk_push) begin
      stk_idx                 <= stk_idx + 2'd1;
      stk_mem[stk_idx + 2'd1] <= stk_wdata;
    end else if (stk_pop) stk_idx <= stk_idx - 2'd1;
  end

  // Register-file model, loadable by the bench at a clock edge.
  logic [7:0] rf [2];
  logic       rf_set;
  logic [7:0] rf_set0, rf_set1;
  assign rf_rdata = rf[rf_addr];
  always @(posedge clk) begin
    if (rf_set) begin
      rf[0] <= rf_set0;
      rf[1] <= rf_set1;
    end else if (rf_we) rf[rf_addr] <= rf_wdata;
  end

  typedef struct {
    bit sv; bit rs; bit clr;
    bit busy; bit done; bit err; int lvl;
    bit push; bit pop; int idx;
    bit chk_top; int top;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(input bit sv, input bit rs, input bit clr,
                              input bit b, input bit d, input bit e, input int lvl,
                              input bit pu, input bit po, input int idx,
                              input bit ct, input int top);
    vec_t v;
    v.sv = sv; v.rs = rs; v.clr = clr;
    v.busy = b; v.done = d; v.err = e; v.lvl = lvl;
    v.push = pu; v.pop = po; v.idx = idx;
    v.chk_top = ct; v.top = top;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      @(negedge clk);
      save_req    = vecs[i].sv;
      restore_req = vecs[i].rs;
      rf_set      = vecs[i].clr;
      rf_set0     = 8'h00;
      rf_set1     = 8'h00;
      #1;
      check($sformatf("v%0d.busy", i),  int'(busy),     int'(vecs[i].busy));
      check($sformatf("v%0d.done", i),  int'(done),     int'(vecs[i].done));
      check($sformatf("v%0d.err", i),   int'(err),      int'(vecs[i].err));
      check($sformatf("v%0d.level", i), int'(level),    vecs[i].lvl);
      check($sformatf("v%0d.push", i),  int'(stk_push), int'(vecs[i].push));
      check($sformatf("v%0d.pop", i),   int'(stk_pop),  int'(vecs[i].pop));
      check($sformatf("v%0d.idx", i),   int'(stk_idx),  vecs[i].idx);
      if (vecs[i].chk_top) check($sformatf("v%0d.top", i), int'(stk_rdata), vecs[i].top);
      $display("vec %0d: save=%0b restore=%0b busy=%0b done=%0b err=%0b level=%0d push=%0b pop=%0b idx=%0d",
               i, save_req, restore_req, busy, done, err, level, stk_push, stk_pop, stk_idx);
    end
  endtask

  int rf_chk_at;

  initial begin
    //            sv rs clr busy done err lvl push pop idx ct top
`ifdef STACK_FRAME_CTRL_CHECK_EN
    vecs.push_back(mk(1,0,0, 0,0,0, 0, 0,0, 3, 0,0));     // save frame A1,B2
    vecs.push_back(mk(0,0,0, 1,0,0, 0, 1,0, 3, 0,0));
    vecs.push_back(mk(0,0,0, 1,0,0, 1, 1,0, 0, 0,0));
    vecs.push_back(mk(0,1,1, 0,1,0, 2, 0,0, 1, 1,8'hB2)); // restore into cleared rf
    vecs.push_back(mk(0,0,0, 1,0,0, 2, 0,1, 1, 1,8'hB2));
    vecs.push_back(mk(0,0,0, 1,0,0, 1, 0,1, 0, 1,8'hA1));
    vecs.push_back(mk(1,0,0, 0,1,0, 0, 0,0, 3, 0,0));
    vecs.push_back(mk(0,0,0, 1,0,0, 0, 1,0, 3, 0,0));
    vecs.push_back(mk(0,0,0, 1,0,0, 1, 1,0, 0, 0,0));
    vecs.push_back(mk(1,0,0, 0,1,0, 2, 0,0, 1, 0,0));
    vecs.push_back(mk(0,0,0, 1,0,0, 2, 1,0, 1, 0,0));
    vecs.push_back(mk(0,0,0, 1,0,0, 3, 1,0, 2, 0,0));
    vecs.push_back(mk(1,0,0, 0,1,0, 4, 0,0, 3, 0,0));     // save at full -> reject
    vecs.push_back(mk(0,0,0, 0,0,1, 4, 0,0, 3, 0,0));
    vecs.push_back(mk(0,1,0, 0,0,0, 4, 0,0, 3, 0,0));
    vecs.push_back(mk(0,0,0, 1,0,0, 4, 0,1, 3, 0,0));
    vecs.push_back(mk(0,0,0, 1,0,0, 3, 0,1, 2, 0,0));
    vecs.push_back(mk(0,1,0, 0,1,0, 2, 0,0, 1, 0,0));
    vecs.push_back(mk(0,0,0, 1,0,0, 2, 0,1, 1, 0,0));
    vecs.push_back(mk(0,0,0, 1,0,0, 1, 0,1, 0, 0,0));
    vecs.push_back(mk(0,1,0, 0,1,0, 0, 0,0, 3, 0,0));     // restore at empty -> reject
    vecs.push_back(mk(0,0,0, 0,0,1, 0, 0,0, 3, 0,0));
    vecs.push_back(mk(1,0,0, 0,0,0, 0, 0,0, 3, 0,0));
    vecs.push_back(mk(0,0,0, 1,0,0, 0, 1,0, 3, 0,0));
    vecs.push_back(mk(0,0,0, 1,0,0, 1, 1,0, 0, 0,0));
    vecs.push_back(mk(1,1,0, 0,1,0, 2, 0,0, 1, 0,0));     // both requests: save wins
    vecs.push_back(mk(0,1,0, 1,0,0, 2, 1,0, 1, 0,0));     // restore while busy ignored
    vecs.push_back(mk(0,1,0, 1,0,0, 3, 1,0, 2, 0,0));
    vecs.push_back(mk(0,0,0, 0,1,0, 4, 0,0, 3, 0,0));
    vecs.push_back(mk(0,1,0, 0,0,0, 4, 0,0, 3, 0,0));
    vecs.push_back(mk(0,0,0, 1,0,0, 4, 0,1, 3, 0,0));
    vecs.push_back(mk(0,0,0, 1,0,0, 3, 0,1, 2, 0,0));
    vecs.push_back(mk(1,0,0, 0,1,0, 2, 0,0, 1, 0,0));
    vecs.push_back(mk(0,0,0, 1,0,0, 2, 1,0, 1, 0,0));     // first SAVE cycle, reset follows
    rf_chk_at = 7;
`else
    vecs.push_back(mk(1,0,0, 0,0,0, 0, 0,0, 3, 0,0));
    vecs.push_back(mk(0,0,0, 1,0,0, 0, 1,0, 3, 0,0));
    vecs.push_back(mk(0,0,0, 1,0,0, 0, 1,0, 0, 0,0));
    vecs.push_back(mk(1,0,0, 0,1,0, 0, 0,0, 1, 0,0));
    vecs.push_back(mk(0,0,0, 1,0,0, 0, 1,0, 1, 0,0));
    vecs.push_back(mk(0,0,0, 1,0,0, 0, 1,0, 2, 0,0));
    vecs.push_back(mk(1,0,0, 0,1,0, 0, 0,0, 3, 0,0));     // third save accepted, index wraps
    vecs.push_back(mk(0,0,0, 1,0,0, 0, 1,0, 3, 0,0));
    vecs.push_back(mk(0,0,0, 1,0,0, 0, 1,0, 0, 0,0));
    vecs.push_back(mk(0,1,0, 0,1,0, 0, 0,0, 1, 1,8'hB2));
    vecs.push_back(mk(0,0,0, 1,0,0, 0, 0,1, 1, 1,8'hB2));
    vecs.push_back(mk(0,0,0, 1,0,0, 0, 0,1, 0, 1,8'hA1));
    vecs.push_back(mk(0,0,0, 0,1,0, 0, 0,0, 3, 0,0));
    vecs.push_back(mk(1,0,0, 0,0,0, 0, 0,0, 3, 0,0));
    vecs.push_back(mk(0,0,0, 1,0,0, 0, 1,0, 3, 0,0));     // first SAVE cycle, reset follows
    rf_chk_at = 13;
`endif

    reset = 1'b1; save_req = 1'b0; restore_req = 1'b0;
    rf_set = 1'b1; rf_set0 = 8'hA1; rf_set1 = 8'hB2;
    repeat (2) @(negedge clk);
    #1;
    check("rst.busy",  int'(busy),     0);
    check("rst.done",  int'(done),     0);
    check("rst.err",   int'(err),      0);
    check("rst.level", int'(level),    0);
    check("rst.push",  int'(stk_push), 0);
    check("rst.pop",   int'(stk_pop),  0);
    check("rst.idx",   int'(stk_idx),  3);
    $display("reset: busy=%0b level=%0d idx=%0d", busy, level, stk_idx);
    @(negedge clk);
    reset  = 1'b0;
    rf_set = 1'b0;

    run_vecs(0, rf_chk_at);
    check("rf0", int'(rf[0]), 8'hA1);
    check("rf1", int'(rf[1]), 8'hB2);
    $display("rf after restore: rf0=%0h rf1=%0h", rf[0], rf[1]);
    run_vecs(rf_chk_at, vecs.size());

    // Reset lands mid-cycle during SAVE; outputs must drop without waiting for an edge.
    reset = 1'b1;
    #1;
    check("midrst.busy",  int'(busy),     0);
    check("midrst.level", int'(level),    0);
    check("midrst.push",  int'(stk_push), 0);
    check("midrst.idx",   int'(stk_idx),  3);
    $display("mid-save reset: busy=%0b level=%0d push=%0b idx=%0d", busy, level, stk_push, stk_idx);
    @(negedge clk);
    reset = 1'b0; save_req = 1'b0; restore_req = 1'b0;
    @(negedge clk);
    #1;
    check("post.busy", int'(busy), 0);
    check("post.done", int'(done), 0);
    $display("after reset release: busy=%0b done=%0b", busy, done);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
